sram_burst_master: RTL and testbench

Initiator-side controller for the team's single-port synchronous byte SRAM (32768 × 8, registered read data, En/Rw control). Accepts burst commands from a host over a valid/ready handshake and issues one SRAM access per cycle. Write bursts consume a byte stream; read bursts return a byte stream with consumer backpressure. It sits between the datapath (or a DMA/host port) and the SRAM instance, and is the only agent that drives the SRAM's Data_in/Addr/Rw/En.

---
 rtl/sram_burst_pkg.sv | 16 +
 rtl/sram_rd_buffer.sv | 51 +++++
 rtl/sram_burst_master.sv | 160 ++++++++++++++++
 tb/tb_sram_burst_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_pkg.sv
// Shared types and constants for the SRAM burst master and its read buffer.
package sram_burst_pkg;

  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_DATA_W   = 8;
  localparam int RD_BUF_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sram_rd_buffer.sv
// Two-entry synchronous FIFO holding bytes returned by the SRAM until the
// read-stream consumer takes them. The caller guarantees no push when full
// and no pop when empty.
module sram_rd_buffer
  import sram_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [RD_BUF_DEPTH];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        count_r;

  // Storage, pointers and occupancy; entries clear on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for the single-port byte SRAM: one access per cycle,
// write bursts from a byte stream, read bursts into a 2-entry buffer.
// Optional feature macro: SRAM_BURST_FILL_EN (constant-fill write bursts).
module sram_burst_master
  import sram_burst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cmd_valid,
  output logic              Cmd_ready,
  input  logic              Cmd_rw,
  input  logic [ADDR_W-1:0] Cmd_addr,
  input  logic [ADDR_W-1:0] Cmd_len,
`ifdef SRAM_BURST_FILL_EN
  input  logic              Cmd_fill,
  input  logic [DATA_W-1:0] Fill_data,
`endif
  input  logic [DATA_W-1:0] Wr_data,
  input  logic              Wr_valid,
  output logic              Wr_ready,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Rd_valid,
  input  logic              Rd_ready,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Mem_data_in,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic              Mem_rw,
  output logic              Mem_en,
  input  logic [DATA_W-1:0] Mem_data_out
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nx;
  logic [ADDR_W-1:0] addr_r, remaining_r, addr_hold_r;
  logic [DATA_W-1:0] data_hold_r, wr_byte_s, buf_head_s;
  logic              inflight_r, wr_beat_s, rd_issue_s, cmd_accept_s, rd_pop_s;
  logic [1:0]        buf_count_s, occupancy_s;
`ifdef SRAM_BURST_FILL_EN
  logic              fill_r;
  logic [DATA_W-1:0] fill_data_r;
`endif

  assign cmd_accept_s = Cmd_valid && (state_r == IDLE);

  // Next state and per-cycle access decision; read credit uses only registered
  // occupancy so the consumer's ready never reaches the SRAM enable.
  always_comb begin
    state_nx    = state_r;
    Wr_ready    = 1'b0;
    wr_beat_s   = 1'b0;
    rd_issue_s  = 1'b0;
    wr_byte_s   = Wr_data;
    occupancy_s = buf_count_s + {1'b0, inflight_r};
    case (state_r)
      IDLE: begin
        if (Cmd_valid) begin
          if (Cmd_rw) state_nx = WRITE;
          else        state_nx = READ;
        end else begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
`ifdef SRAM_BURST_FILL_EN
        if (fill_r) begin
          wr_beat_s = 1'b1;
          wr_byte_s = fill_data_r;
        end else begin
          Wr_ready  = 1'b1;
          wr_beat_s = Wr_valid;
        end
`else
        Wr_ready  = 1'b1;
        wr_beat_s = Wr_valid;
`endif
        if (wr_beat_s && (remaining_r == '0)) state_nx = DONE;
        else                                  state_nx = WRITE;
      end
      READ: begin
        rd_issue_s = (occupancy_s < 2'd2);
        if (rd_issue_s && (remaining_r == '0)) state_nx = DRAIN;
        else                                   state_nx = READ;
      end
      DRAIN: begin
        if ((buf_count_s == 2'd0) && !inflight_r) state_nx = DONE;
        else                                      state_nx = DRAIN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control state, burst address/count, in-flight flag and held SRAM bus values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      remaining_r <= '0;
      addr_hold_r <= '0;
      data_hold_r <= '0;
      inflight_r  <= 1'b0;
    end else begin
      state_r    <= state_nx;
      inflight_r <= rd_issue_s;
      if (cmd_accept_s) begin
        addr_r      <= Cmd_addr;
        remaining_r <= Cmd_len;
      end else if (Mem_en) begin
        addr_r      <= addr_r + ADDR_ONE;
        remaining_r <= remaining_r - ADDR_ONE;
      end
      if (Mem_en) begin
        addr_hold_r <= addr_r;
      end
      if (wr_beat_s) begin
        data_hold_r <= wr_byte_s;
      end
    end
  end

`ifdef SRAM_BURST_FILL_EN
  // Fill mode and fill byte are captured with the command.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fill_r      <= 1'b0;
      fill_data_r <= '0;
    end else if (cmd_accept_s) begin
      fill_r      <= Cmd_fill & Cmd_rw;
      fill_data_r <= Fill_data;
    end
  end
`endif

  sram_rd_buffer #(.DATA_W(DATA_W)) u_rd_buffer (
    .clk       (Clk),
    .rst       (Rst),
    .push      (inflight_r),
    .push_data (Mem_data_out),
    .pop       (rd_pop_s),
    .head      (buf_head_s),
    .count     (buf_count_s)
  );

  assign rd_pop_s    = Rd_valid & Rd_ready;
  assign Rd_valid    = (buf_count_s != 2'd0);
  assign Rd_data     = buf_head_s;
  assign Cmd_ready   = (state_r == IDLE);
  assign Busy        = (state_r != IDLE);
  assign Done        = (state_r == DONE);
  assign Mem_en      = wr_beat_s | rd_issue_s;
  assign Mem_rw      = wr_beat_s;
  assign Mem_addr    = Mem_en ? addr_r : addr_hold_r;
  assign Mem_data_in = wr_beat_s ? wr_byte_s : data_hold_r;

endmodule

// File: tb/tb_sram_burst_master.sv
// Randomized scoreboard bench for sram_burst_master with a behavioural SRAM
// and byte-array reference model. Fill tests run when SRAM_BURST_FILL_EN is defined.
module tb_sram_burst_master;

  localparam int MEM_N = 32768;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Cmd_valid, Cmd_ready, Cmd_rw;
  logic [14:0] Cmd_addr, Cmd_len;
  logic [7:0]  Wr_data;
  logic        Wr_valid, Wr_ready;
  logic [7:0]  Rd_data;
  logic        Rd_valid, Rd_ready, Busy, Done;
  logic [7:0]  Mem_data_in;
  logic [14:0] Mem_addr;
  logic        Mem_rw, Mem_en;
  logic [7:0]  Mem_data_out = 8'h00;
`ifdef SRAM_BURST_FILL_EN
  logic        Cmd_fill;
  logic [7:0]  Fill_data;
`endif

  sram_burst_master dut (
    .Clk(Clk), .Rst(Rst),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_rw(Cmd_rw),
    .Cmd_addr(Cmd_addr), .Cmd_len(Cmd_len),
`ifdef SRAM_BURST_FILL_EN
    .Cmd_fill(Cmd_fill), .Fill_data(Fill_data),
`endif
    .Wr_data(Wr_data), .Wr_valid(Wr_valid), .Wr_ready(Wr_ready),
    .Rd_data(Rd_data), .Rd_valid(Rd_valid), .Rd_ready(Rd_ready),
    .Busy(Busy), .Done(Done),
    .Mem_data_in(Mem_data_in), .Mem_addr(Mem_addr), .Mem_rw(Mem_rw),
    .Mem_en(Mem_en), .Mem_data_out(Mem_data_out)
  );

  always #5 Clk = ~Clk;

  // Behavioural SRAM: registered read data, write on En & Rw.
  bit [7:0] sram [MEM_N];
  always @(posedge Clk) begin
    if (Mem_en) begin
      if (Mem_rw) sram[Mem_addr] <= Mem_data_in;
      else        Mem_data_out   <= sram[Mem_addr];
    end
  end

  // Reference contents and scoreboards.
  typedef struct packed { logic [14:0] addr; logic [7:0] data; } wbeat_t;
  bit [7:0]   ref_mem [MEM_N];
  wbeat_t     exp_wq [$];
  logic [7:0] exp_rq [$];
  logic [7:0] fixed_q [$];

  int n_pass = 0, n_total = 0;
  int done_cnt = 0, pops_total = 0, rd_issued = 0, rd_popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops scoreboards whenever the DUT issues a write or hands over a read byte.
  always @(negedge Clk) begin
    wbeat_t     wexp;
    logic [7:0] rexp;
    if (Rst) begin
      rd_issued = 0;
      rd_popped = 0;
    end else begin
      if (Done) done_cnt++;
      if (!Mem_en) check("mem_rw_low_when_idle", Mem_rw, 1'b0);
      if (Mem_en && !Mem_rw) begin
        check("read_credit_below_two", (rd_issued - rd_popped) < 2, 1'b1);
        rd_issued++;
      end
      if (Mem_en && Mem_rw) begin
        if (exp_wq.size() == 0) fail("unexpected_sram_write");
        else begin
          wexp = exp_wq.pop_front();
          check("write_addr", Mem_addr, wexp.addr);
          check("write_data", Mem_data_in, wexp.data);
        end
      end
      if (Rd_valid && Rd_ready) begin
        pops_total++;
        rd_popped++;
        if (exp_rq.size() == 0) fail("unexpected_read_byte");
        else begin
          rexp = exp_rq.pop_front();
          check("read_data", Rd_data, rexp);
        end
      end
    end
  end

  task automatic send_cmd(input logic rw, input int a, input int len, output bit ok);
    int k;
    k = 0;
    while (Cmd_ready !== 1'b1 && k < 200) begin
      @(posedge Clk); #1; k++;
    end
    ok = (Cmd_ready === 1'b1);
    if (!ok) begin
      fail("cmd_accept_timeout");
      return;
    end
    Cmd_valid = 1'b1;
    Cmd_rw    = rw;
    Cmd_addr  = a[14:0];
    Cmd_len   = len[14:0];
    @(posedge Clk); #1;
    Cmd_valid = 1'b0;
  endtask

  // mode 0: Wr_valid held high; 1: Wr_valid from pat bit per cycle; 2: random.
  task automatic write_burst(input int a, input int n, input int mode, input logic [31:0] pat, input logic fill);
    logic [7:0] wb [$];
    logic [7:0] d;
    bit ok;
    int idx, beat_k, done_k, d0;
    for (int i = 0; i < n; i++) begin
      if (fill)                   d = 8'hA5;
      else if (fixed_q.size() > 0) d = fixed_q.pop_front();
      else                        d = 8'($urandom);
      wb.push_back(d);
      ref_mem[(a + i) % MEM_N] = d;
      exp_wq.push_back({15'((a + i) % MEM_N), d});
    end
`ifdef SRAM_BURST_FILL_EN
    Cmd_fill  = fill;
    Fill_data = 8'hA5;
`endif
    d0 = done_cnt;
    send_cmd(1'b1, a, n - 1, ok);
`ifdef SRAM_BURST_FILL_EN
    Cmd_fill = 1'b0;
`endif
    if (!ok) return;
    idx = 0; beat_k = 0; done_k = 0;
    for (int k = 1; k <= 4 * n + 40 && done_k == 0; k++) begin
      if (!fill && idx < n) begin
        case (mode)
          0:       Wr_valid = 1'b1;
          1:       Wr_valid = (k <= 32) ? pat[k-1] : 1'b1;
          default: Wr_valid = 1'($urandom_range(0, 1));
        endcase
        Wr_data = wb[idx];
      end else begin
        Wr_valid = 1'b0;
      end
      @(negedge Clk);
      if (idx < n) begin
        if (fill) check("fill_wr_ready_low", Wr_ready, 1'b0);
        else      check("wr_en_follows_valid", Mem_en, Wr_valid);
        if (Mem_en && Mem_rw) begin
          idx++;
          if (idx == n) beat_k = k;
        end
      end
      if (Done) done_k = k;
      @(posedge Clk); #1;
    end
    Wr_valid = 1'b0;
    check("write_done_seen", done_k != 0, 1'b1);
    check("write_done_after_last_beat", done_k, beat_k + 1);
    if (mode == 0 || fill) check("write_done_latency", done_k, n + 1);
    check("write_done_pulses", done_cnt - d0, 1);
    check("write_done_one_cycle", Done, 1'b0);
  endtask

  // rmode 0: Rd_ready high; 1: toggling 1/0; 2: random.
  task automatic read_burst(input int a, input int n, input int rmode);
    bit ok;
    int p0, d0, fi, fv, done_k;
    for (int i = 0; i < n; i++) exp_rq.push_back(ref_mem[(a + i) % MEM_N]);
    p0 = pops_total; d0 = done_cnt;
    send_cmd(1'b0, a, n - 1, ok);
    if (!ok) return;
    fi = 0; fv = 0; done_k = 0;
    for (int k = 1; k <= 6 * n + 40 && done_k == 0; k++) begin
      case (rmode)
        0:       Rd_ready = 1'b1;
        1:       Rd_ready = 1'(k % 2);
        default: Rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge Clk);
      if (fi == 0 && Mem_en && !Mem_rw) fi = k;
      if (fv == 0 && Rd_valid) fv = k;
      if (Done) done_k = k;
      @(posedge Clk); #1;
    end
    Rd_ready = 1'b0;
    check("read_done_seen", done_k != 0, 1'b1);
    check("read_bytes_delivered", pops_total - p0, n);
    check("read_queue_drained", exp_rq.size(), 0);
    check("read_first_issue_cycle", fi, 1);
    check("read_first_valid_latency", fv - fi, 2);
    check("read_done_pulses", done_cnt - d0, 1);
    check("read_done_one_cycle", Done, 1'b0);
  endtask

  initial begin
    bit ok;
    int k, p0, d0, a;
    Cmd_valid = 1'b0; Cmd_rw = 1'b0; Cmd_addr = 15'h0; Cmd_len = 15'h0;
    Wr_data = 8'h00; Wr_valid = 1'b0; Rd_ready = 1'b0;
`ifdef SRAM_BURST_FILL_EN
    Cmd_fill = 1'b0; Fill_data = 8'h00;
`endif
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst_cmd_ready", Cmd_ready, 1'b1);
    check("rst_wr_ready", Wr_ready, 1'b0);
    check("rst_rd_valid", Rd_valid, 1'b0);
    check("rst_rd_data", Rd_data, 8'h00);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_mem_en", Mem_en, 1'b0);
    check("rst_mem_rw", Mem_rw, 1'b0);
    check("rst_mem_addr", Mem_addr, 15'h0);
    check("rst_mem_data_in", Mem_data_in, 8'h00);
    @(posedge Clk); #1;

    // Directed write then read-back of four known bytes.
    fixed_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(32'h0010, 4, 0, 32'h0, 1'b0);
    read_burst(32'h0010, 4, 0);

    // Eight-byte read with Rd_ready toggling.
    write_burst(32'h0200, 8, 0, 32'h0, 1'b0);
    read_burst(32'h0200, 8, 1);

    // Address wrap at the top of the SRAM.
    write_burst(32'h7FFE, 3, 0, 32'h0, 1'b0);
    read_burst(32'h7FFE, 3, 0);

    // Gapped write stream 1,0,0,1,1.
    write_burst(32'h0300, 3, 1, 32'b11001, 1'b0);
    read_burst(32'h0300, 3, 2);

    // Reset in the middle of an eight-beat read.
    for (int i = 0; i < 8; i++) exp_rq.push_back(ref_mem[16 + i]);
    p0 = pops_total; d0 = done_cnt;
    send_cmd(1'b0, 32'h0010, 7, ok);
    Rd_ready = 1'b1;
    k = 0;
    while (pops_total - p0 < 3 && k < 100) begin
      @(negedge Clk); #1; k++;
    end
    check("reset_mid_pops_before", pops_total - p0, 3);
    @(posedge Clk); #1;
    Rst = 1'b1; Rd_ready = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("mid_rst_rd_valid", Rd_valid, 1'b0);
    check("mid_rst_mem_en", Mem_en, 1'b0);
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    check("mid_rst_cmd_ready", Cmd_ready, 1'b1);
    check("mid_rst_no_done_pulse", done_cnt - d0, 0);
    exp_rq.delete();
    write_burst(32'h0400, 5, 0, 32'h0, 1'b0);
    read_burst(32'h0400, 5, 0);

`ifdef SRAM_BURST_FILL_EN
    // Constant fill with the write stream idle.
    write_burst(32'h0100, 16, 0, 32'h0, 1'b1);
    read_burst(32'h0100, 16, 0);
`endif

    // Randomized bursts, every other one near the wrap point.
    for (int r = 0; r < 10; r++) begin
      a = (r % 2 == 0) ? int'($urandom_range(32760, 32767)) : int'($urandom_range(0, 32767));
      write_burst(a, int'($urandom_range(1, 10)), 2, 32'h0, 1'b0);
      read_burst((a + int'($urandom_range(0, 3))) % MEM_N, int'($urandom_range(1, 10)), 2);
    end

    repeat (2) @(posedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
